// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Contents: FSM state encoding, BCD accumulator layout, nibble width,
// saturation value and default widths.
package bin2bcd_pkg;

  localparam int unsigned IN_W_DEF     = 8;
  localparam int unsigned CNT_W_DEF    = 4;
  localparam int unsigned BCD_NIBBLE_W = 4;
  localparam int unsigned ACC_W        = 3 * BCD_NIBBLE_W;
  localparam logic [7:0]  SAT_VALUE    = 8'h99;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  // Hundreds, tens and ones digits as they sit in the shift accumulator.
  typedef struct packed {
    logic [BCD_NIBBLE_W-1:0] hund;
    logic [BCD_NIBBLE_W-1:0] tens;
    logic [BCD_NIBBLE_W-1:0] ones;
  } bcd_acc_t;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble nibble correction: adds 3 when the digit is 5 or more so
// that the following left shift carries correctly into the next digit.
// Ports: nibble (4-bit digit in), adjusted (4-bit corrected digit out).
module bcd_add3_nibble
  import bin2bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] nibble,
  output logic [BCD_NIBBLE_W-1:0] adjusted
);

  // Only digits 5..9 ever reach here, so the 4-bit add never wraps.
  assign adjusted = (nibble >= BCD_NIBBLE_W'(5)) ? nibble + BCD_NIBBLE_W'(3) : nibble;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 8-bit binary to packed BCD for the
// 7-segment display driver, one bit per clock.
// Ports: clk, rst_n (async active-low), start, bin_in[7:0] (captured on the
// accepting edge), busy, done (1-cycle pulse), bcd_out[7:0] (tens/ones),
// hundreds[1:0], overflow (value > 99).
// Build option: define BIN2BCD_SATURATE_EN to show 8'h99 on bcd_out for
// any value above 99.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  output logic            busy,
  output logic            done,
  output logic [7:0]      bcd_out,
  output logic [1:0]      hundreds,
  output logic            overflow
);

  state_t            state, state_nx;
  logic              busy_nx, done_nx;
  logic              load, step, publish;
  bcd_acc_t          acc;
  logic [IN_W-1:0]   bin_sr;
  logic [CNT_W-1:0]  cnt;

  logic [BCD_NIBBLE_W-1:0] adj_hund, adj_tens, adj_ones;
  logic [ACC_W+IN_W-1:0]   dd_shift;

  // Per-digit add-3 correction ahead of the shift.
  bcd_add3_nibble u_add3_hund (.nibble(acc.hund), .adjusted(adj_hund));
  bcd_add3_nibble u_add3_tens (.nibble(acc.tens), .adjusted(adj_tens));
  bcd_add3_nibble u_add3_ones (.nibble(acc.ones), .adjusted(adj_ones));

  assign dd_shift = {adj_hund, adj_tens, adj_ones, bin_sr} << 1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nx = state;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    publish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          busy_nx  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        step    = 1'b1;
        busy_nx = 1'b1;
        if (cnt == CNT_W'(IN_W - 1)) begin
          busy_nx  = 1'b0;
          state_nx = DONE_ST;
        end
      end
      DONE_ST: begin
        publish  = 1'b1;
        done_nx  = 1'b1;
        state_nx = IDLE;
        // Back-to-back request skips the idle cycle.
        if (start) begin
          load     = 1'b1;
          busy_nx  = 1'b1;
          state_nx = SHIFT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shift datapath and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      bin_sr <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      bin_sr <= bin_in;
      cnt    <= '0;
    end else if (step) begin
      acc    <= dd_shift[ACC_W+IN_W-1:IN_W];
      bin_sr <= dd_shift[IN_W-1:0];
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Registered outputs; result fields only change on the publish cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= 8'h00;
      hundreds <= 2'd0;
      overflow <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
      if (publish) begin
        hundreds <= acc.hund[1:0];
        overflow <= (acc.hund != '0);
`ifdef BIN2BCD_SATURATE_EN
        bcd_out  <= (acc.hund != '0) ? SAT_VALUE : {acc.tens, acc.ones};
`else
        bcd_out  <= {acc.tens, acc.ones};
`endif
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: cycle model built from decimal
// arithmetic plus directed conversions with literal expected digits.
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] bin_in = 8'h00;
  logic       busy, done, overflow;
  logic [7:0] bcd_out;
  logic [1:0] hundreds;

  int errors = 0;
  int checks = 0;

  bin2bcd_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .hundreds (hundreds),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] disp_digits(input int v);
    int r;
    r = v % 100;
`ifdef BIN2BCD_SATURATE_EN
    if (v > 99) return 8'h99;
`endif
    return 8'(((r / 10) << 4) | (r % 10));
  endfunction

  // Model: a conversion is "edges since acceptance"; result appears 9 edges later.
  bit         m_active = 1'b0;
  int         m_k = 0;
  int         m_val = 0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_ov = 1'b0;
  logic [7:0] m_bcd = 8'h00;
  logic [1:0] m_hund = 2'd0;

  always @(posedge clk or negedge rst_n) begin : model
    bit   act;
    int   k, val;
    logic d;
    if (!rst_n) begin
      m_active <= 1'b0; m_k <= 0; m_val <= 0;
      m_busy <= 1'b0; m_done <= 1'b0; m_ov <= 1'b0;
      m_bcd <= 8'h00; m_hund <= 2'd0;
    end else begin
      act = m_active; k = m_k; val = m_val; d = 1'b0;
      if (act) begin
        k++;
        if (k == 9) begin
          act = 1'b0;
          d   = 1'b1;
          m_bcd  <= disp_digits(val);
          m_hund <= 2'(val / 100);
          m_ov   <= (val > 99);
        end
      end
      if (!act && start) begin
        act = 1'b1; k = 0; val = int'(bin_in);
      end
      m_active <= act; m_k <= k; m_val <= val;
      m_done   <= d;
      m_busy   <= act && (k <= 7);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("cyc_busy", 16'(busy), 16'(m_busy));
    check("cyc_done", 16'(done), 16'(m_done));
    check("cyc_bcd", 16'(bcd_out), 16'(m_bcd));
    check("cyc_hund", 16'(hundreds), 16'(m_hund));
    check("cyc_ovf", 16'(overflow), 16'(m_ov));
  end

  // Raise start for the accepting edge; return 1ns after it.
  task automatic do_start(input logic [7:0] v, input bit keep);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
    bin_in = 8'($urandom_range(0, 255));
  endtask

  // Wait for done (entered 1ns after the accepting edge) and check result.
  task automatic wait_done(input string tag, input bit timing, input logic [7:0] eb,
                           input logic [1:0] eh, input logic eo);
    int  bcnt;
    int  lat;
    bit  seen;
    bcnt = busy ? 1 : 0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else if (busy) begin
        bcnt++;
      end
    end
    check({tag, "_seen"}, 16'(seen), 16'd1);
    if (timing) begin
      check({tag, "_lat"}, 16'(lat), 16'd9);
      check({tag, "_busycyc"}, 16'(bcnt), 16'd8);
    end
    check({tag, "_bcd"}, 16'(bcd_out), 16'(eb));
    check({tag, "_hund"}, 16'(hundreds), 16'(eh));
    check({tag, "_ovf"}, 16'(overflow), 16'(eo));
  endtask

`ifdef BIN2BCD_SATURATE_EN
  localparam logic [7:0] EXP_255 = 8'h99;
  localparam logic [7:0] EXP_100 = 8'h99;
`else
  localparam logic [7:0] EXP_255 = 8'h55;
  localparam logic [7:0] EXP_100 = 8'h00;
`endif

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_bcd", 16'(bcd_out), 16'h00);
    check("rst_hund", 16'(hundreds), 16'd0);
    check("rst_ovf", 16'(overflow), 16'd0);

    do_start(8'd0, 1'b0);   wait_done("v0", 1'b1, 8'h00, 2'd0, 1'b0);
    do_start(8'd42, 1'b0);  wait_done("v42", 1'b1, 8'h42, 2'd0, 1'b0);
    do_start(8'd99, 1'b0);  wait_done("v99", 1'b1, 8'h99, 2'd0, 1'b0);
    do_start(8'd255, 1'b0); wait_done("v255", 1'b1, EXP_255, 2'd2, 1'b1);
    // Outputs hold between conversions.
    repeat (4) @(negedge clk);
    check("hold_bcd", 16'(bcd_out), 16'(EXP_255));
    do_start(8'd100, 1'b0); wait_done("v100", 1'b1, EXP_100, 2'd1, 1'b0 | 1'b1);
    do_start(8'd9, 1'b0);   wait_done("v9", 1'b1, 8'h09, 2'd0, 1'b0);

    // start while busy is ignored
    do_start(8'd17, 1'b0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; bin_in = 8'd200;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("busy_ign", 1'b0, 8'h17, 2'd0, 1'b0);
    repeat (12) @(negedge clk);
    check("busy_ign_idle", 16'(busy), 16'd0);
    check("busy_ign_keep", 16'(bcd_out), 16'h17);

    // back-to-back: start held, new value presented on the done edge
    do_start(8'd23, 1'b1);
    bin_in = 8'd58;
    wait_done("b2b_a", 1'b1, 8'h23, 2'd0, 1'b0);
    start = 1'b0;
    bin_in = 8'd3;
    wait_done("b2b_b", 1'b1, 8'h58, 2'd0, 1'b0);

    // reset during the 5th SHIFT cycle
    do_start(8'd77, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_bcd", 16'(bcd_out), 16'h00);
    check("mid_rst_hund", 16'(hundreds), 16'd0);
    check("mid_rst_ovf", 16'(overflow), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_rst_nodone", 16'(bcd_out), 16'h00);
    do_start(8'd77, 1'b0);  wait_done("v77", 1'b1, 8'h77, 2'd0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
